// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus: ROM address/data, redirect/halt control and the decode handshake.
// The fetch controller takes the master view; the ROM and decode side take the slave view.
interface instr_fetch_ctrl_if;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    modport master (
        output rom_addr,
        input  rom_data,
        input  redirect_valid,
        input  redirect_pc,
        input  halt,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc,
        output fetch_fault
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output redirect_valid,
        output redirect_pc,
        output halt,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc,
        input  fetch_fault
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads a combinational ROM and buffers
// {word, pc} pairs in a 2-entry FIFO toward decode; handles redirect, halt and faults.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ROM_DEPTH  = 62,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    instr_fetch_ctrl_if.master bus
);
    localparam logic [1:0]  S_RUN     = 2'd0;
    localparam logic [1:0]  S_HALTED  = 2'd1;
    localparam logic [1:0]  S_FAULT   = 2'd2;
    localparam logic [29:0] ROM_WORDS = 30'(ROM_DEPTH);
    localparam logic [1:0]  FULL_CNT  = 2'(FIFO_DEPTH);

    logic [31:0] r_pc;
    logic [1:0]  r_state;
    logic [31:0] r_data [FIFO_DEPTH];
    logic [31:0] r_ipc  [FIFO_DEPTH];
    logic        r_head;
    logic [1:0]  r_count;

    logic w_active, w_run, w_redir, w_misalign, w_pop;
    logic w_push_try, w_oor, w_fault, w_push, w_tail;

    assign w_active   = (r_state != S_FAULT);
    assign w_run      = w_active && !bus.halt;
    assign w_redir    = w_active && bus.redirect_valid;
    assign w_misalign = w_redir && (bus.redirect_pc[1:0] != 2'b00);
    // A redirect discards the head, so it must not also count as a pop.
    assign w_pop      = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;
    assign w_push_try = w_run && !bus.redirect_valid &&
                        ((r_count < FULL_CNT) || ((r_count == FULL_CNT) && w_pop));
    assign w_oor      = (r_pc[31:2] >= ROM_WORDS);
    assign w_fault    = w_misalign || (w_push_try && w_oor);
    assign w_push     = w_push_try && !w_oor;
    // head+count mod 2; with count==2 this lands on the slot being popped.
    assign w_tail     = r_head ^ r_count[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc     <= RESET_PC;
            r_state  <= S_RUN;
            r_head   <= 1'b0;
            r_count  <= 2'd0;
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_ipc[0]  <= '0;
            r_ipc[1]  <= '0;
        end else if (w_fault) begin
            r_state <= S_FAULT;
            r_count <= 2'd0;
            if (w_misalign)
                r_pc <= bus.redirect_pc;
        end else if (w_redir) begin
            r_pc    <= bus.redirect_pc;
            r_count <= 2'd0;
            r_state <= bus.halt ? S_HALTED : S_RUN;
        end else if (w_active) begin
            r_state <= bus.halt ? S_HALTED : S_RUN;
            if (w_push) begin
                r_data[w_tail] <= bus.rom_data;
                r_ipc[w_tail]  <= r_pc;
                r_pc           <= r_pc + 32'd4;
            end
            if (w_pop)
                r_head <= ~r_head;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign bus.rom_addr    = r_pc;
    assign bus.instr_valid = (r_count != 2'd0);
    assign bus.instr_data  = r_data[r_head];
    assign bus.instr_pc    = r_ipc[r_head];
    assign bus.fetch_fault = (r_state == S_FAULT);
endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Instruction fetch sequencer for the single-cycle instruction ROM (combinational, word-indexed by addr[31:2]). Owns the PC, drives the ROM address, and buffers fetched words with their PC in a 2-entry FIFO. Presents the words to decode over a valid/ready handshake. Handles branch/jump redirect, halt, and fetch faults for misaligned or out-of-range PCs.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset (must be word-aligned)
ROM_DEPTH, 62, number of valid ROM words; legal PC range is 0 .. 4*ROM_DEPTH-4
FIFO_DEPTH, 2, fetch buffer entries (fixed at 2; other values unsupported)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
rom_addr  output  32  byte address to ROM; equals the PC register
rom_data  input  32  ROM word, combinational from rom_addr
redirect_valid  input  1  load new PC this cycle (branch/jump taken)
redirect_pc  input  32  redirect target byte address
halt  input  1  level; suppress new fetches while high
instr_valid  output  1  FIFO head holds a valid instruction
instr_ready  input  1  decode accepts head this cycle
instr_data  output  32  instruction word at FIFO head
instr_pc  output  32  byte address of instr_data
fetch_fault  output  1  sticky fault flag; fetch stopped

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. On reset_n=0: pc=RESET_PC, FIFO count=0, instr_valid=0, instr_data=0, instr_pc=0, fetch_fault=0, state=RUN. rom_addr=pc, so it reads RESET_PC during reset.
- States:
  - RUN: fetching.
  - HALTED: halt=1, no fetch.
  - FAULT: terminal until reset.
- State transitions:
  - RUN->HALTED when halt=1.
  - HALTED->RUN when halt=0.
  - Any->FAULT on a fault condition.
  - FAULT exits only by reset.
- Push: in RUN, with no redirect and pc legal, if count<2 or (count==2 and pop this cycle):
  - write {rom_data, pc} to FIFO tail
  - pc <= pc+4
- Pop: instr_valid && instr_ready. Head advances at the clock edge.
- Simultaneous push and pop: count is unchanged.
- Latency: a word fetched at edge N is visible on instr_data/instr_pc/instr_valid after edge N, i.e. 1 cycle PC-to-output. After reset release, the first instr_valid=1 follows the first rising edge.
- Throughput: 1 instruction/cycle with instr_ready held high.
- Backpressure: with instr_ready=0 and FIFO full, pc holds and rom_addr is stable. Head data must not change while instr_valid=1 and instr_ready=0.
- Redirect (highest priority, any state except FAULT):
  - flush FIFO (count<=0, instr_valid<=0 next cycle)
  - pc <=redirect_pc
  - no push and no pop that cycle
  - a concurrent instr_ready is ignored; the head is discarded
- Redirect while halt=1: loads the PC and flushes, but no fetch occurs until halt=0.
- Fault conditions (checked at the edge):
  - redirect_valid with redirect_pc[1:0]!=0
  - a push attempt with pc[31:2] >= ROM_DEPTH
- On fault:
  - FIFO flushed
  - fetch_fault<=1 (sticky)
  - instr_valid=0
  - pc frozen at the offending value; on a misaligned redirect it holds redirect_pc
- PC arithmetic: 32-bit unsigned, pc[1:0] is always 0. Wrap past 32'hFFFF_FFFC cannot occur because the range check faults first.
- Reset mid-operation: asynchronous clear of all state regardless of FIFO contents, redirect, or halt. Outputs reach reset values without waiting for a clock edge.

Test Plan:
- Streaming: reset, instr_ready=1, ROM preloaded 0x002081B3 (add) / 0x402081B3 (sub) / 0x002091B3 (sll) at words 0/1/2 -> instr_pc 0x0,0x4,0x8 on consecutive cycles with matching instr_data; fetch_fault=0.
- Backpressure: instr_ready=0 from reset -> after 2 edges count=2, rom_addr holds 0x8, head stays {0x0, 0x002081B3}. Release instr_ready -> pcs 0x0,0x4,0x8 delivered in order with no loss or duplication.
- Redirect: while streaming, redirect_valid=1, redirect_pc=0x24 -> instr_valid=0 next cycle, then instr_pc=0x24, instr_data=0x0020F1B3 (and); the prior queued entries are never delivered.
- Misaligned redirect: redirect_pc=0x06 -> fetch_fault=1 and instr_valid=0 permanently; rom_addr=0x06. Assert reset_n=0 mid-cycle -> immediate clear, fetch restarts at 0x0.
- Range fault: redirect_pc=0xF4 (word 61), instr_ready=1 -> word 61 delivered, then pc=0xF8 faults; fetch_fault=1, no instr_pc=0xF8 ever seen.
- Halt: halt=1 for 5 cycles while streaming -> FIFO drains, then instr_valid=0 and pc constant. Halt=0 -> fetch resumes at the next sequential pc.
